// File: rtl/bt_rx_ctrl.sv
// bt_rx_ctrl: Bluetooth UART receive-path controller.
//   Generates the divided bit clock for the serial receiver, captures each
//   byte the receiver flags as available into a small FIFO, and shares that
//   FIFO between two consumers with a round-robin request/grant handshake.
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   en                enables bit-clock generation and byte capture
//   clk_div           bit clock to receiver, period 2*HALF clk cycles
//   rx_avail, rx_data receiver byte-available flag and data byte
//   req0, req1        consumer read requests (level)
//   gnt0, gnt1        one-cycle grants; data_out valid while high
//   data_out          last popped byte, held until the next grant
//   count             FIFO occupancy
//   overrun, clr_ovr  sticky byte-dropped flag and its synchronous clear
module bt_rx_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   clk_div,
  input  logic                   rx_avail,
  input  logic [7:0]             rx_data,
  input  logic                   req0,
  input  logic                   req1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic [7:0]             data_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   clr_ovr
);

  localparam int HALF = CLK_HZ / (2 * BAUD);
  localparam int AW   = $clog2(DEPTH);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  logic [DW-1:0] div_cnt;
  logic          s1, s2, s3;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state;
  logic          last1;   // 1: consumer 1 was granted last
  logic          push, full, wr_en, ovf, pop, pick1;

  // Bit clock divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      clk_div <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      clk_div <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_div <= ~clk_div;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // rx_avail synchronizer plus delay flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_avail;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    push  = s2 & ~s3 & en;
    full  = (count == FULL_CNT);   // pre-edge occupancy: a same-cycle pop does not make room
    wr_en = push & ~full;
    ovf   = push & full;
    pop   = (state == ST_IDLE) && (count != '0) && (req0 | req1);
    // lone requester wins; under contention the one not granted last wins
    pick1 = req1 & (~req0 | ~last1);
  end

  // Storage needs no reset: occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      state    <= ST_IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      data_out <= '0;
      last1    <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ovf)          overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            last1    <= pick1;
            state    <= ST_GRANT;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
          end
        end
        ST_GRANT: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bt_rx_ctrl.sv
module tb_bt_rx_ctrl;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 2;
  localparam int DEPTH  = 4;
  localparam int HALF   = CLK_HZ / (2 * BAUD);
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, en, rx_avail, req0, req1, clr_ovr;
  logic [7:0]    rx_data;
  logic          clk_div, gnt0, gnt1, overrun;
  logic [7:0]    data_out;
  logic [CW-1:0] count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bt_rx_ctrl #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clk_div (clk_div),
    .rx_avail(rx_avail),
    .rx_data (rx_data),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .data_out(data_out),
    .count   (count),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  // Reference model: FIFO as a queue, rx_avail history, enabled-cycle count
  byte unsigned q[$];
  bit           hist[$];     // rx_avail samples, newest at back
  bit           m_ovr, m_g0, m_g1, m_last1;
  byte unsigned m_data;
  int unsigned  m_n;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist = '{0, 0, 0};
    m_ovr = 0; m_g0 = 0; m_g1 = 0; m_last1 = 1; m_data = 0; m_n = 0;
  endtask

  task automatic model_edge();
    int  sz;
    bit  rise, pk1, pop;
    sz   = q.size();
    // byte is taken on the 3rd edge after rx_avail is first seen high
    rise = hist[hist.size()-2] && !hist[hist.size()-3] && en;
    pop  = !(m_g0 || m_g1) && sz > 0 && (req0 || req1);
    if (pop) begin
      pk1     = req1 && (!req0 || !m_last1);
      m_data  = q.pop_front();
      m_g0    = !pk1;
      m_g1    = pk1;
      m_last1 = pk1;
    end else begin
      m_g0 = 0;
      m_g1 = 0;
    end
    if (rise && sz == DEPTH) m_ovr = 1;
    else if (clr_ovr)        m_ovr = 0;
    if (rise && sz < DEPTH) q.push_back(rx_data);
    hist.push_back(rx_avail);
    void'(hist.pop_front());
    m_n = en ? m_n + 1 : 0;
  endtask

  task automatic check_all();
    check("count",    count,    q.size());
    check("gnt0",     gnt0,     m_g0);
    check("gnt1",     gnt1,     m_g1);
    check("gnt_excl", gnt0 & gnt1, 0);
    check("data_out", data_out, m_data);
    check("overrun",  overrun,  m_ovr);
    check("clk_div",  clk_div,  (m_n / HALF) % 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push_byte(input byte unsigned b);
    rx_data  = b;
    rx_avail = 1;
    step();
    rx_avail = 0;
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  byte unsigned got_b[$];
  bit           got_w[$];
  byte unsigned exp_b[4];
  bit           exp_w[4];

  initial begin
    rst_n = 0; en = 0; rx_avail = 0; rx_data = 0;
    req0 = 0; req1 = 0; clr_ovr = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1;

    // divider
    en = 1;
    repeat (4) step();
    check("div_first_toggle", clk_div, 1);
    repeat (16) step();
    en = 0;
    step();
    check("div_en_off", clk_div, 0);
    en = 1;
    repeat (3) step();

    // capture latency and single push per long pulse
    rx_data  = 8'hA5;
    rx_avail = 1;
    step(); check("cap_e1", count, 0);
    step(); check("cap_e2", count, 0);
    step(); check("cap_e3", count, 1);
    repeat (17) step();
    check("cap_single", count, 1);
    rx_avail = 0;
    step();
    req0 = 1;
    step();
    check("cap_gnt0", gnt0, 1);
    check("cap_data", data_out, 8'hA5);
    check("cap_empty", count, 0);
    req0 = 0;
    repeat (2) step();

    // overflow
    for (int unsigned i = 1; i <= 5; i++) push_byte(8'(i));
    check("ovf_count", count, 4);
    check("ovf_flag", overrun, 1);
    req0 = 1;
    for (int unsigned i = 1; i <= 4; i++) begin
      step();
      check("ovf_pop_gnt", gnt0, 1);
      check("ovf_pop_data", data_out, i);
      step();
    end
    req0 = 0;
    step();
    check("ovf_drained", count, 0);
    clr_ovr = 1;
    step();
    clr_ovr = 0;
    check("ovf_clr", overrun, 0);

    // round-robin under constant contention
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    req0 = 1; req1 = 1;
    repeat (12) begin
      step();
      if (gnt0 || gnt1) begin
        got_b.push_back(data_out);
        got_w.push_back(gnt1);
      end
    end
    req0 = 0; req1 = 0;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_w = '{0, 1, 0, 1};
    check("arb_ngrants", got_b.size(), 4);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < got_b.size()) begin
        check("arb_data", got_b[i], exp_b[i]);
        check("arb_who", got_w[i], exp_w[i]);
      end
    end

    // push and pop on the same edge at count=2
    push_byte(8'hAA); push_byte(8'hBB);
    rx_data = 8'hCC; rx_avail = 1;
    step();
    rx_avail = 0;
    step();
    req0 = 1;
    step();
    check("pp_count", count, 2);
    check("pp_data", data_out, 8'hAA);
    step(); step();
    check("pp_data2", data_out, 8'hBB);
    step(); step();
    check("pp_data3", data_out, 8'hCC);
    req0 = 0;
    step();

    // async reset during GRANT with three bytes left
    for (int unsigned i = 0; i < 4; i++) push_byte(8'(8'h71 + i));
    req0 = 1;
    step();
    check("rst_pre_gnt", gnt0, 1);
    check("rst_pre_cnt", count, 3);
    req0 = 0;
    rst_n = 0;
    #1;
    check("rst_cnt", count, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_data", data_out, 0);
    model_reset();
    check_all();
    #2;
    rst_n = 1;
    push_byte(8'h81); push_byte(8'h82);
    req0 = 1; req1 = 1;
    step();
    check("rst_tie_gnt0", gnt0, 1);
    check("rst_tie_data", data_out, 8'h81);
    step(); step();
    check("rst_tie_gnt1", gnt1, 1);
    req0 = 0; req1 = 0;
    step();

    // randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      en      = ($urandom_range(0, 19) != 0);
      req0    = ($urandom_range(0, 9) < 3);
      req1    = ($urandom_range(0, 9) < 3);
      clr_ovr = ($urandom_range(0, 15) == 0);
      if (!rx_avail && $urandom_range(0, 2) == 0) begin
        rx_data  = 8'($urandom);
        rx_avail = 1;
      end else if (rx_avail && $urandom_range(0, 2) == 0) begin
        rx_avail = 0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
